// File: rtl/simmem_pkg.sv
// Shared parameters for the simulated-memory write response path.
package simmem_pkg;

    // Number of AXI IDs the response path tracks, and the width of an ID.
    localparam int unsigned NumIds  = 16;
    localparam int unsigned IDWidth = $clog2(NumIds);

    // Total number of write responses the response bank can hold.
    localparam int unsigned WriteRespBankTotalCapacity = 32;

    // Per-ID release credit counter width: wide enough to count every
    // response the bank could ever hold for a single ID.
    localparam int unsigned WriteRespReleaseCntWidth = $clog2(WriteRespBankTotalCapacity + 1);

    // Release scheduler FSM states. The state register doubles as pop valid.
    localparam logic [0:0] SchedIdle  = 1'b0;
    localparam logic [0:0] SchedOffer = 1'b1;

endpackage : simmem_pkg

// File: rtl/simmem_wresp_release_sched_if.sv
// Pop-grant handshake between the release scheduler and the response bank.
interface simmem_wresp_release_sched_if #(
    parameter int unsigned IdWidth = simmem_pkg::IDWidth
);

    logic               valid;
    logic [IdWidth-1:0] id;
    logic               ready;

    // Scheduler side: offers grants.
    modport master (
        output valid,
        output id,
        input  ready
    );

    // Bank side: accepts grants.
    modport slave (
        input  valid,
        input  id,
        output ready
    );

endinterface : simmem_wresp_release_sched_if

// File: rtl/simmem_rr_arbiter.sv
// Combinational round-robin arbiter. Searches req starting at ptr and
// wrapping modulo NumIds; the first requester found wins.
module simmem_rr_arbiter #(
    parameter int unsigned NumIds  = simmem_pkg::NumIds,
    parameter int unsigned IdWidth = simmem_pkg::IDWidth
) (
    input  logic [NumIds-1:0]  req,
    input  logic [IdWidth-1:0] ptr,
    output logic               gnt_valid,
    output logic [IdWidth-1:0] gnt_id
);

    // Walk the request vector in rotated order and latch the first hit.
    always_comb begin
        // NOTE: every output gets a default before the search so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int unsigned off = 0; off < NumIds; off++) begin
            int unsigned idx;
            idx = (int'(ptr) + off) % NumIds;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = IdWidth'(idx);
            end
        end
    end

endmodule : simmem_rr_arbiter

// File: rtl/simmem_wresp_release_sched.sv
// Write response release scheduler. Counts per-ID release credits, picks
// one eligible ID per grant in round-robin order and offers it to the
// response bank over a valid/ready handshake. The credit is debited when an
// ID is loaded into the offer register, not when the bank accepts it.
module simmem_wresp_release_sched
    import simmem_pkg::*;
#(
    parameter int unsigned NumIds   = simmem_pkg::NumIds,
    parameter int unsigned CntWidth = simmem_pkg::WriteRespReleaseCntWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumIds-1:0]                   release_en_i,
    input  logic [NumIds-1:0]                   bank_nonempty_i,
    simmem_wresp_release_sched_if.master        pop,
    output logic                                overflow_o
);

    localparam int unsigned IdWidth = (NumIds > 1) ? $clog2(NumIds) : 1;
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    // Credit counters, round-robin pointer, offer register, sticky flag.
    logic [CntWidth-1:0] cnt_q [NumIds];
    logic [CntWidth-1:0] cnt_d [NumIds];
    logic [IdWidth-1:0]  ptr_q;
    logic [0:0]          state_q;
    logic [IdWidth-1:0]  id_q;
    logic                overflow_q;

    logic [NumIds-1:0]   eligible;
    logic [NumIds-1:0]   sel;
    logic [NumIds-1:0]   sat_hit;
    logic                gnt_valid;
    logic [IdWidth-1:0]  gnt_id;
    logic                handshake;
    logic                load;

    // An ID is eligible when it holds credit and the bank has a response for it.
    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            eligible[i] = (cnt_q[i] != '0) && bank_nonempty_i[i];
        end
    end

    simmem_rr_arbiter #(
        .NumIds  (NumIds),
        .IdWidth (IdWidth)
    ) u_arbiter (
        .req       (eligible),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // A new ID is loaded when the offer register is empty or being drained.
    assign handshake = (state_q == SchedOffer) && pop.ready;
    assign load      = gnt_valid && ((state_q == SchedIdle) || pop.ready);

    // One-hot selection of the ID loaded this cycle.
    always_comb begin
        sel = '0;
        if (load) begin
            sel[gnt_id] = 1'b1;
        end
    end

    // Next credit per ID: +release, -selection, saturating at CntMax.
    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            cnt_d[i]   = cnt_q[i];
            sat_hit[i] = 1'b0;
            case ({release_en_i[i], sel[i]})
                2'b10: begin
                    if (cnt_q[i] == CntMax) begin
                        sat_hit[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntWidth'(1);
                    end
                end
                2'b01:   cnt_d[i] = cnt_q[i] - CntWidth'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Credit counter storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: this array is reset element by element because credits
            // must read zero the moment reset asserts; a plain data memory
            // would be left unreset.
            for (int unsigned i = 0; i < NumIds; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            for (int unsigned i = 0; i < NumIds; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Offer FSM: load on selection, drop valid on an undrained handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SchedIdle;
            id_q    <= '0;
        end else if (load) begin
            state_q <= SchedOffer;
            id_q    <= gnt_id;
        end else if (handshake) begin
            state_q <= SchedIdle;
        end
    end

    // Round-robin pointer moves past each selected ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= IdWidth'((int'(gnt_id) + 1) % NumIds);
        end
    end

    // Sticky overflow: a release arrived for an already saturated counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (|sat_hit) begin
            overflow_q <= 1'b1;
        end
    end

    assign pop.valid  = (state_q == SchedOffer);
    assign pop.id     = id_q;
    assign overflow_o = overflow_q;

endmodule : simmem_wresp_release_sched

// File: tb/tb_simmem_wresp_release_sched.sv
// Directed bench for the write response release scheduler.
module tb_simmem_wresp_release_sched;
    import simmem_pkg::*;

    localparam int unsigned N  = NumIds;
    localparam int unsigned IW = IDWidth;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] rel;
    logic [N-1:0] nonempty;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    simmem_wresp_release_sched_if #(.IdWidth(IW)) pop_if ();

    simmem_wresp_release_sched dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .release_en_i    (rel),
        .bank_nonempty_i (nonempty),
        .pop             (pop_if),
        .overflow_o      (ovf)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        rel          = '0;
        nonempty     = '0;
        pop_if.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_offer(input string tag, input logic v, input int unsigned id);
        check({tag, ".valid"}, 32'(pop_if.valid), 32'(v));
        if (v) check({tag, ".id"}, 32'(pop_if.id), 32'(id));
    endtask

    function automatic logic [N-1:0] bit_of(input int unsigned i);
        logic [N-1:0] b;
        b    = '0;
        b[i] = 1'b1;
        return b;
    endfunction

    initial begin
        // Reset values.
        rst          = 1'b1;
        rel          = '0;
        nonempty     = '0;
        pop_if.ready = 1'b0;
        #1;
        check("rst.valid", 32'(pop_if.valid), 0);
        check("rst.id",    32'(pop_if.id),    0);
        check("rst.ovf",   32'(ovf),          0);
        do_reset();

        // 1: single credit on ID 3.
        nonempty     = bit_of(3);
        pop_if.ready = 1'b1;
        rel          = bit_of(3);
        tick();
        rel = '0;
        chk_offer("t1.c1", 1'b0, 0);
        tick();
        chk_offer("t1.c2", 1'b1, 3);
        check("t1.cnt3", 32'(dut.cnt_q[3]), 0);
        tick();
        chk_offer("t1.c3", 1'b0, 0);

        // 2: round robin 2,5,9 then wrap to 2,9.
        do_reset();
        nonempty     = bit_of(2) | bit_of(5) | bit_of(9);
        pop_if.ready = 1'b1;
        rel          = nonempty;
        tick();
        rel = '0;
        tick();
        chk_offer("t2.g0", 1'b1, 2);
        tick();
        chk_offer("t2.g1", 1'b1, 5);
        tick();
        chk_offer("t2.g2", 1'b1, 9);
        tick();
        chk_offer("t2.idle", 1'b0, 0);
        rel = bit_of(2) | bit_of(9);
        tick();
        rel = '0;
        tick();
        chk_offer("t2.g3", 1'b1, 2);
        tick();
        chk_offer("t2.g4", 1'b1, 9);
        tick();
        chk_offer("t2.end", 1'b0, 0);

        // 3: offer held under backpressure while credits accumulate.
        do_reset();
        nonempty = bit_of(5);
        rel      = bit_of(5);
        tick();
        rel = '0;
        tick();
        chk_offer("t3.load", 1'b1, 5);
        check("t3.cnt0", 32'(dut.cnt_q[5]), 0);
        for (int k = 0; k < 4; k++) begin
            rel = (k == 0 || k == 2) ? bit_of(5) : '0;
            tick();
            chk_offer($sformatf("t3.hold%0d", k), 1'b1, 5);
        end
        rel = '0;
        check("t3.cnt2", 32'(dut.cnt_q[5]), 2);
        pop_if.ready = 1'b1;
        tick();
        chk_offer("t3.re", 1'b1, 5);
        check("t3.cnt1", 32'(dut.cnt_q[5]), 1);
        tick();
        chk_offer("t3.re2", 1'b1, 5);
        check("t3.cntz", 32'(dut.cnt_q[5]), 0);
        tick();
        chk_offer("t3.end", 1'b0, 0);

        // 4: selection and release on the same ID in the same cycle.
        do_reset();
        nonempty     = bit_of(7);
        pop_if.ready = 1'b1;
        rel          = bit_of(7);
        tick();
        check("t4.cnt1", 32'(dut.cnt_q[7]), 1);
        tick();
        rel = '0;
        chk_offer("t4.g0", 1'b1, 7);
        check("t4.cnt_same", 32'(dut.cnt_q[7]), 1);
        tick();
        chk_offer("t4.g1", 1'b1, 7);
        check("t4.cnt0", 32'(dut.cnt_q[7]), 0);
        tick();
        chk_offer("t4.end", 1'b0, 0);

        // 5: saturation on ID 0 with an empty bank.
        do_reset();
        pop_if.ready = 1'b1;
        rel          = bit_of(0);
        for (int k = 0; k < 63; k++) tick();
        check("t5.cnt63", 32'(dut.cnt_q[0]), 63);
        check("t5.ovf_pre", 32'(ovf), 0);
        tick();
        rel = '0;
        check("t5.cnt_sat", 32'(dut.cnt_q[0]), 63);
        check("t5.ovf", 32'(ovf), 1);
        chk_offer("t5.novalid", 1'b0, 0);
        tick();
        check("t5.ovf_sticky", 32'(ovf), 1);

        // 6: asynchronous reset in the middle of an offer.
        nonempty     = bit_of(1);
        pop_if.ready = 1'b0;
        rel          = bit_of(1);
        tick();
        rel = '0;
        tick();
        chk_offer("t6.offer", 1'b1, 1);
        #2 rst = 1'b1;
        #1;
        check("t6.valid", 32'(pop_if.valid), 0);
        check("t6.id",    32'(pop_if.id),    0);
        check("t6.ovf",   32'(ovf),          0);
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("t6.cnt%0d", i), 32'(dut.cnt_q[i]), 0);
        end
        tick();
        rst          = 1'b0;
        nonempty     = '1;
        pop_if.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_offer($sformatf("t6.quiet%0d", k), 1'b0, 0);
        end
        rel = bit_of(4);
        tick();
        rel = '0;
        tick();
        chk_offer("t6.grant", 1'b1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_simmem_wresp_release_sched
